trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Sequences machine-mode trap entry and MRET return for the core.
- Arbitrates between synchronous exceptions, MRET and pending interrupts (MEI/MSI/MTI).
- Flushes the pipeline, then drives the trap/MRET write port of the CSR register block, then issues the PC redirect to fetch.
- Sits between commit stage, CSR register block and fetch unit.

Parameters:
VECTORED_EN, 1, 1 = honour mtvec mode 1 (vectored interrupts); 0 = all traps go to mtvec base.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
exc_valid  input  1  commit stage reports synchronous exception (single-cycle strobe)
exc_cause  input  31  exception code
exc_pc  input  32  PC of faulting instruction
exc_tval  input  32  trap value for exception
mret_valid  input  1  MRET at commit (strobe)
irq_boundary  input  1  pipeline at instruction boundary; interrupt may be taken
irq_pc  input  32  PC of next unexecuted instruction
mstatus_mie  input  1  from CSR block
mstatus_mpie  input  1  from CSR block
mie_msie, mie_mtie, mie_meie  input  1 each  enables from CSR block
mip_msip, mip_mtip, mip_meip  input  1 each  pending bits from CSR block
mtvec  input  32  trap vector CSR
mepc  input  32  exception PC CSR
flush_req  output  1  request pipeline drain
flush_ack  input  1  pipeline drained
trap_wr_en  output  1  one-cycle CSR trap write strobe
trap_mie  output  1  new mstatus.MIE
trap_mpie  output  1  new mstatus.MPIE
trap_pc_in  output  32  mepc value
trap_int  output  1  mcause interrupt bit
trap_cause  output  31  mcause code
trap_val  output  32  mtval value
mret_wr_en  output  1  one-cycle CSR MRET write strobe
mret_mie  output  1  restored mstatus.MIE
mret_mpie  output  1  mstatus.MPIE after MRET
redirect_valid  output  1  redirect fetch
redirect_pc  output  32  target PC
redirect_ready  input  1  fetch accepts redirect
busy  output  1  state != IDLE

Behaviour:
- All outputs registered.
- Reset: state IDLE; every output 0; latched event cleared.
- Reset asserted in any state aborts the sequence; no CSR strobe is issued afterwards.
- States: IDLE, FLUSH, COMMIT, REDIRECT.
- IDLE, event selection, in priority order:
  - exc_valid;
  - else mret_valid;
  - else interrupt, if irq_boundary && mstatus_mie && any (mip_x & mie_x).
- Interrupt priority: MEI (cause 11) > MSI (3) > MTI (7).
- On a selected event, latch kind, cause, pc, tval, mstatus_mie and mstatus_mpie, then go to FLUSH.
- Exception+MRET in the same cycle: exception taken, MRET dropped. Exception+interrupt: exception taken; interrupt re-evaluated on return to IDLE.
- FLUSH: flush_req=1. On the cycle flush_ack=1 (sampled in FLUSH), go to COMMIT and drop flush_req next cycle. Minimum FLUSH duration is 1 cycle.
- Events arriving while not in IDLE are ignored. Interrupt pending/enable changes after latch do not cancel the trap.
- COMMIT (exactly 1 cycle):
  - Trap: trap_wr_en=1, trap_mie=0, trap_mpie=latched mstatus_mie, trap_pc_in=latched pc, trap_int=1 for interrupt, trap_cause=latched cause, trap_val=latched tval (0 for interrupt).
  - MRET: mret_wr_en=1, mret_mie=latched mstatus_mpie, mret_mpie=1.
  - Go to REDIRECT.
- Redirect target, computed in COMMIT:
  - Exception: {mtvec[31:2],2'b00}.
  - Interrupt: base + 4*cause when VECTORED_EN && mtvec[1:0]==1, else base. mtvec[1:0] = 2 or 3 is treated as direct.
  - MRET: {mepc[31:2],2'b00}.
  - Arithmetic is 32-bit modulo 2^32.
- REDIRECT: redirect_valid=1, redirect_pc stable until redirect_ready. On the handshake cycle go to IDLE; redirect_valid=0 next cycle.
- A new event may be accepted the cycle after returning to IDLE.
- Latency: event at cycle N → flush_req at N+1. If flush_ack is seen at cycle M, CSR strobe is at M+1 and redirect_valid at M+2.

Test Plan:
- Illegal-instruction exception: exc_cause=2, exc_pc=0x8AB4, exc_tval=0xFFEEDD11, mstatus_mie=1, flush_ack high → one-cycle trap_wr_en with trap_int=0, trap_cause=2, trap_mpie=1, trap_mie=0; redirect_pc=0x4 with mtvec=0x4.
- Vectored MEI: mtvec=0x101, all mip/mie bits=1, mstatus_mie=1, irq_boundary=1, irq_pc=0x8A9C → trap_int=1, trap_cause=11, trap_val=0, trap_pc_in=0x8A9C, redirect_pc=0x12C. Repeat with VECTORED_EN=0 → redirect_pc=0x100.
- Masking: pending MTI with mstatus_mie=0, or with irq_boundary=0 → no flush_req and busy=0 for 10 cycles.
- Simultaneous exc_valid, mret_valid and pending MSI → exception taken. After return, MSI is taken (cause 3) on the next eligible boundary.
- MRET: mepc=0x2003, mstatus_mpie=1 → mret_wr_en pulse with mret_mie=1, mret_mpie=1; redirect_pc=0x2000. Hold redirect_ready low 3 cycles → redirect_valid and redirect_pc stay stable.
- Reset asserted during FLUSH with flush_ack delayed → all outputs 0 immediately. No trap_wr_en after reset release; IDLE.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer: selects the event, drains the pipeline,
// then issues the CSR trap/MRET write and finally redirects fetch.
module trap_ctrl #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [30:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic        irq_boundary,
  input  logic [31:0] irq_pc,
  input  logic        mstatus_mie,
  input  logic        mstatus_mpie,
  input  logic        mie_msie,
  input  logic        mie_mtie,
  input  logic        mie_meie,
  input  logic        mip_msip,
  input  logic        mip_mtip,
  input  logic        mip_meip,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        flush_req,
  input  logic        flush_ack,
  output logic        trap_wr_en,
  output logic        trap_mie,
  output logic        trap_mpie,
  output logic [31:0] trap_pc_in,
  output logic        trap_int,
  output logic [30:0] trap_cause,
  output logic [31:0] trap_val,
  output logic        mret_wr_en,
  output logic        mret_mie,
  output logic        mret_mpie,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_COMMIT, ST_REDIRECT} state_e;
  typedef enum logic [1:0] {EV_EXC, EV_MRET, EV_IRQ} kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [30:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tval_q, tval_d;
  logic        lmie_q, lmie_d;
  logic        lmpie_q, lmpie_d;

  logic        flush_req_q, flush_req_d;
  logic        trap_wr_en_q, trap_wr_en_d;
  logic        trap_mpie_q, trap_mpie_d;
  logic [31:0] trap_pc_in_q, trap_pc_in_d;
  logic        trap_int_q, trap_int_d;
  logic [30:0] trap_cause_q, trap_cause_d;
  logic [31:0] trap_val_q, trap_val_d;
  logic        mret_wr_en_q, mret_wr_en_d;
  logic        mret_mie_q, mret_mie_d;
  logic        mret_mpie_q, mret_mpie_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        busy_q, busy_d;

  logic        irq_ext, irq_sw, irq_tmr, irq_take;
  logic [30:0] irq_cause;
  logic [31:0] tvec_base, redirect_target;

  // Fixed interrupt priority: external > software > timer.
  always_comb begin
    irq_ext   = mip_meip & mie_meie;
    irq_sw    = mip_msip & mie_msie;
    irq_tmr   = mip_mtip & mie_mtie;
    irq_take  = irq_boundary & mstatus_mie & (irq_ext | irq_sw | irq_tmr);
    irq_cause = irq_ext ? 31'd11 : (irq_sw ? 31'd3 : 31'd7);
  end

  // NOTE: every variable gets a default before the case so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    tval_d  = tval_q;
    lmie_d  = lmie_q;
    lmpie_d = lmpie_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          kind_d  = EV_EXC;
          cause_d = exc_cause;
          pc_d    = exc_pc;
          tval_d  = exc_tval;
          state_d = ST_FLUSH;
        end else if (mret_valid) begin
          kind_d  = EV_MRET;
          cause_d = '0;
          pc_d    = '0;
          tval_d  = '0;
          state_d = ST_FLUSH;
        end else if (irq_take) begin
          kind_d  = EV_IRQ;
          cause_d = irq_cause;
          pc_d    = irq_pc;
          tval_d  = '0;
          state_d = ST_FLUSH;
        end
        if (state_d == ST_FLUSH) begin
          lmie_d  = mstatus_mie;
          lmpie_d = mstatus_mpie;
        end
      end
      ST_FLUSH:    if (flush_ack) state_d = ST_COMMIT;
      ST_COMMIT:   state_d = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Only mtvec mode 1 vectors, and only for interrupts; modes 2/3 fall back to direct.
  always_comb begin
    tvec_base = {mtvec[31:2], 2'b00};
    case (kind_q)
      EV_MRET: redirect_target = mepc & 32'hFFFF_FFFC;
      EV_IRQ:  redirect_target = (VECTORED_EN && mtvec[1:0] == 2'b01)
                                 ? tvec_base + {cause_q[29:0], 2'b00} : tvec_base;
      default: redirect_target = tvec_base;
    endcase
  end

  always_comb begin
    flush_req_d      = (state_d == ST_FLUSH);
    busy_d           = (state_d != ST_IDLE);
    redirect_valid_d = (state_d == ST_REDIRECT);
    redirect_pc_d    = (state_q == ST_COMMIT) ? redirect_target : redirect_pc_q;
    trap_wr_en_d     = 1'b0;
    trap_mpie_d      = 1'b0;
    trap_pc_in_d     = '0;
    trap_int_d       = 1'b0;
    trap_cause_d     = '0;
    trap_val_d       = '0;
    mret_wr_en_d     = 1'b0;
    mret_mie_d       = 1'b0;
    mret_mpie_d      = 1'b0;
    if (state_q == ST_FLUSH && flush_ack) begin
      if (kind_q == EV_MRET) begin
        mret_wr_en_d = 1'b1;
        mret_mie_d   = lmpie_q;
        mret_mpie_d  = 1'b1;
      end else begin
        trap_wr_en_d = 1'b1;
        trap_mpie_d  = lmie_q;
        trap_pc_in_d = pc_q;
        trap_int_d   = (kind_q == EV_IRQ);
        trap_cause_d = cause_q;
        trap_val_d   = tval_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      kind_q           <= EV_EXC;
      cause_q          <= '0;
      pc_q             <= '0;
      tval_q           <= '0;
      lmie_q           <= 1'b0;
      lmpie_q          <= 1'b0;
      flush_req_q      <= 1'b0;
      trap_wr_en_q     <= 1'b0;
      trap_mpie_q      <= 1'b0;
      trap_pc_in_q     <= '0;
      trap_int_q       <= 1'b0;
      trap_cause_q     <= '0;
      trap_val_q       <= '0;
      mret_wr_en_q     <= 1'b0;
      mret_mie_q       <= 1'b0;
      mret_mpie_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      kind_q           <= kind_d;
      cause_q          <= cause_d;
      pc_q             <= pc_d;
      tval_q           <= tval_d;
      lmie_q           <= lmie_d;
      lmpie_q          <= lmpie_d;
      flush_req_q      <= flush_req_d;
      trap_wr_en_q     <= trap_wr_en_d;
      trap_mpie_q      <= trap_mpie_d;
      trap_pc_in_q     <= trap_pc_in_d;
      trap_int_q       <= trap_int_d;
      trap_cause_q     <= trap_cause_d;
      trap_val_q       <= trap_val_d;
      mret_wr_en_q     <= mret_wr_en_d;
      mret_mie_q       <= mret_mie_d;
      mret_mpie_q      <= mret_mpie_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
    end
  end

  // Trap entry always clears mstatus.MIE, so this output is tied low.
  assign trap_mie       = 1'b0;
  assign flush_req      = flush_req_q;
  assign trap_wr_en     = trap_wr_en_q;
  assign trap_mpie      = trap_mpie_q;
  assign trap_pc_in     = trap_pc_in_q;
  assign trap_int       = trap_int_q;
  assign trap_cause     = trap_cause_q;
  assign trap_val       = trap_val_q;
  assign mret_wr_en     = mret_wr_en_q;
  assign mret_mie       = mret_mie_q;
  assign mret_mpie      = mret_mpie_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = busy_q;

endmodule
